// File: rtl/ext_mem_arbiter.sv
// Two-port arbiter for the external partial-sum memory (port 0 = MAC RMW engine, port 1 = drain/host).
// Optional grant/stall statistics counters are compiled in with EXT_MEM_ARB_STATS_EN.
module ext_mem_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_in,
  input  logic                  p0_valid,
  output logic                  p0_ready,
  input  logic                  p0_we,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  input  logic [DATA_WIDTH-1:0] p0_wdata,
  input  logic                  p0_lock,
  output logic                  p0_rsp_valid,
  output logic [DATA_WIDTH-1:0] p0_rsp_data,
  input  logic                  p1_valid,
  output logic                  p1_ready,
  input  logic                  p1_we,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  input  logic [DATA_WIDTH-1:0] p1_wdata,
  output logic                  p1_rsp_valid,
  output logic [DATA_WIDTH-1:0] p1_rsp_data,
  output logic                  ext_mem_read_en,
  output logic [ADDR_WIDTH-1:0] ext_mem_read_addr,
  input  logic [DATA_WIDTH-1:0] ext_mem_qout,
  output logic                  ext_mem_write_en,
  output logic [ADDR_WIDTH-1:0] ext_mem_write_addr,
  output logic [DATA_WIDTH-1:0] ext_mem_din,
  output logic                  busy
`ifdef EXT_MEM_ARB_STATS_EN
  ,
  output logic [15:0]           p0_grant_cnt,
  output logic [15:0]           p1_grant_cnt,
  output logic [15:0]           p1_stall_cnt
`endif
);

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  logic [3:0]            starve_cnt_reg, starve_cnt_next;
  logic [1:0]            req_valid, req_sel, xfer_vec;
  logic                  xfer, sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  logic                  read_en_reg, write_en_reg;
  logic [ADDR_WIDTH-1:0] read_addr_reg, write_addr_reg;
  logic [DATA_WIDTH-1:0] din_reg;
  logic                  rd_tag_reg;
  logic                  rsp_valid_reg, rsp_tag_reg;

  logic [1:0]            rsp_hit;
  logic [DATA_WIDTH-1:0] rsp_data_vec [2];

  assign req_valid = {p1_valid, p0_valid};

  // Priority: lock, then starvation relief for port 1, then port 0, else port 1 by default.
  always_comb begin
    req_sel = 2'b00;
    if (rst_in) begin
      req_sel = 2'b00;
    end else if (p0_lock) begin
      req_sel = 2'b01;
    end else if ((starve_cnt_reg == STARVE_MAX) && p1_valid) begin
      req_sel = 2'b10;
    end else if (p0_valid) begin
      req_sel = 2'b01;
    end else begin
      req_sel = 2'b10;
    end
  end

  assign p0_ready = req_sel[0];
  assign p1_ready = req_sel[1];
  assign xfer_vec = req_valid & req_sel;
  assign xfer     = |xfer_vec;

  assign sel_we    = req_sel[1] ? p1_we    : p0_we;
  assign sel_addr  = req_sel[1] ? p1_addr  : p0_addr;
  assign sel_wdata = req_sel[1] ? p1_wdata : p0_wdata;

  always_comb begin
    starve_cnt_next = 4'd0;
    if (p1_valid && !req_sel[1]) begin
      starve_cnt_next = (starve_cnt_reg == STARVE_MAX) ? STARVE_MAX : starve_cnt_reg + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_in) begin
      starve_cnt_reg <= 4'd0;
      read_en_reg    <= 1'b0;
      write_en_reg   <= 1'b0;
      read_addr_reg  <= '0;
      write_addr_reg <= '0;
      din_reg        <= '0;
      rd_tag_reg     <= 1'b0;
      rsp_valid_reg  <= 1'b0;
      rsp_tag_reg    <= 1'b0;
    end else begin
      starve_cnt_reg <= starve_cnt_next;
      read_en_reg    <= xfer && !sel_we;
      write_en_reg   <= xfer && sel_we;
      if (xfer && sel_we) begin
        write_addr_reg <= sel_addr;
        din_reg        <= sel_wdata;
      end
      if (xfer && !sel_we) begin
        read_addr_reg <= sel_addr;
        rd_tag_reg    <= req_sel[1];
      end
      // The tag travels one stage behind the read command to steer qout.
      rsp_valid_reg <= read_en_reg;
      rsp_tag_reg   <= rd_tag_reg;
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
    assign rsp_hit[gi]      = rsp_valid_reg && (rsp_tag_reg == 1'(gi));
    assign rsp_data_vec[gi] = rsp_hit[gi] ? ext_mem_qout : '0;
  end

  assign p0_rsp_valid = rsp_hit[0];
  assign p1_rsp_valid = rsp_hit[1];
  assign p0_rsp_data  = rsp_data_vec[0];
  assign p1_rsp_data  = rsp_data_vec[1];

  assign ext_mem_read_en    = read_en_reg;
  assign ext_mem_read_addr  = read_addr_reg;
  assign ext_mem_write_en   = write_en_reg;
  assign ext_mem_write_addr = write_addr_reg;
  assign ext_mem_din        = din_reg;
  assign busy               = read_en_reg || rsp_valid_reg;

`ifdef EXT_MEM_ARB_STATS_EN
  logic [15:0] grant_cnt_reg [2];
  logic [15:0] stall_cnt_reg;

  for (genvar gi = 0; gi < 2; gi++) begin : g_grant_cnt
    always_ff @(posedge clk) begin
      if (rst_in) begin
        grant_cnt_reg[gi] <= 16'd0;
      end else if (xfer_vec[gi] && (grant_cnt_reg[gi] != 16'hFFFF)) begin
        grant_cnt_reg[gi] <= grant_cnt_reg[gi] + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_in) begin
      stall_cnt_reg <= 16'd0;
    end else if (p1_valid && !req_sel[1] && (stall_cnt_reg != 16'hFFFF)) begin
      stall_cnt_reg <= stall_cnt_reg + 16'd1;
    end
  end

  assign p0_grant_cnt = grant_cnt_reg[0];
  assign p1_grant_cnt = grant_cnt_reg[1];
  assign p1_stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_ext_mem_arbiter.sv
// Bench for ext_mem_arbiter: directed scenarios then random traffic, each cycle checked
// against a transaction-level model (grant rules, shadow memory, 2-cycle read pipeline).
module tb_ext_mem_arbiter;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int SL = 4;

  logic          clk = 1'b0;
  logic          rst_in;
  logic          p0_valid, p0_ready, p0_we, p0_lock, p0_rsp_valid;
  logic [AW-1:0] p0_addr;
  logic [DW-1:0] p0_wdata, p0_rsp_data;
  logic          p1_valid, p1_ready, p1_we, p1_rsp_valid;
  logic [AW-1:0] p1_addr;
  logic [DW-1:0] p1_wdata, p1_rsp_data;
  logic          ext_mem_read_en, ext_mem_write_en, busy;
  logic [AW-1:0] ext_mem_read_addr, ext_mem_write_addr;
  logic [DW-1:0] ext_mem_qout, ext_mem_din;
`ifdef EXT_MEM_ARB_STATS_EN
  logic [15:0]   p0_grant_cnt, p1_grant_cnt, p1_stall_cnt;
`endif

  always #5 clk = ~clk;

  ext_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .rst_in(rst_in),
    .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_we(p0_we), .p0_addr(p0_addr),
    .p0_wdata(p0_wdata), .p0_lock(p0_lock), .p0_rsp_valid(p0_rsp_valid), .p0_rsp_data(p0_rsp_data),
    .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_we(p1_we), .p1_addr(p1_addr),
    .p1_wdata(p1_wdata), .p1_rsp_valid(p1_rsp_valid), .p1_rsp_data(p1_rsp_data),
    .ext_mem_read_en(ext_mem_read_en), .ext_mem_read_addr(ext_mem_read_addr),
    .ext_mem_qout(ext_mem_qout), .ext_mem_write_en(ext_mem_write_en),
    .ext_mem_write_addr(ext_mem_write_addr), .ext_mem_din(ext_mem_din), .busy(busy)
`ifdef EXT_MEM_ARB_STATS_EN
    , .p0_grant_cnt(p0_grant_cnt), .p1_grant_cnt(p1_grant_cnt), .p1_stall_cnt(p1_stall_cnt)
`endif
  );

  // External memory: 1-cycle read latency, write-first on a same-address collision.
  logic [DW-1:0] env_mem [256];
  logic [DW-1:0] qout_reg = '0;
  always @(posedge clk) begin
    if (ext_mem_write_en) env_mem[ext_mem_write_addr] <= ext_mem_din;
    if (ext_mem_read_en)
      qout_reg <= (ext_mem_write_en && ext_mem_write_addr == ext_mem_read_addr) ? ext_mem_din
                                                                                : env_mem[ext_mem_read_addr];
  end
  assign ext_mem_qout = qout_reg;

  // Reference model state
  typedef struct {
    bit          v;
    bit          we;
    bit          port;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } op_t;

  int            n_cmp = 0;
  int            n_err = 0;
  logic [DW-1:0] ref_mem [256];
  int            starve;
  op_t           cmd_q, rsp_q, no_op;
  int            g_cnt [2];
  int            stall;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_grant();
    if (rst_in) return -1;
    if (p0_lock) return 0;
    if (starve == SL && p1_valid) return 1;
    if (p0_valid) return 0;
    return 1;
  endfunction

  task automatic accept(input bit port, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cmd_q.v = 1'b1; cmd_q.we = we; cmd_q.port = port; cmd_q.addr = a;
    if (we) begin
      cmd_q.data = d;
      ref_mem[a] = d;
    end else begin
      cmd_q.data = ref_mem[a];
    end
    if (g_cnt[port] < 16'hFFFF) g_cnt[port]++;
  endtask

  // One clock: check outputs at negedge, advance the model at posedge.
  task automatic cyc();
    int  g;
    bit  rd_cmd;
    @(negedge clk);
    g      = model_grant();
    rd_cmd = cmd_q.v && !cmd_q.we;
    chk("p0_ready", p0_ready, g == 0);
    chk("p1_ready", p1_ready, g == 1);
    chk("read_en", ext_mem_read_en, rd_cmd);
    chk("write_en", ext_mem_write_en, cmd_q.v && cmd_q.we);
    if (rd_cmd) chk("read_addr", ext_mem_read_addr, cmd_q.addr);
    if (cmd_q.v && cmd_q.we) begin
      chk("write_addr", ext_mem_write_addr, cmd_q.addr);
      chk("din", ext_mem_din, cmd_q.data);
    end
    chk("p0_rsp_valid", p0_rsp_valid, rsp_q.v && rsp_q.port == 1'b0);
    chk("p1_rsp_valid", p1_rsp_valid, rsp_q.v && rsp_q.port == 1'b1);
    if (rsp_q.v && rsp_q.port == 1'b0) chk("p0_rsp_data", p0_rsp_data, rsp_q.data);
    if (rsp_q.v && rsp_q.port == 1'b1) chk("p1_rsp_data", p1_rsp_data, rsp_q.data);
    chk("busy", busy, rd_cmd || rsp_q.v);
`ifdef EXT_MEM_ARB_STATS_EN
    chk("p0_grant_cnt", p0_grant_cnt, g_cnt[0]);
    chk("p1_grant_cnt", p1_grant_cnt, g_cnt[1]);
    chk("p1_stall_cnt", p1_stall_cnt, stall);
`endif
    @(posedge clk);
    if (rst_in) begin
      starve = 0; cmd_q = no_op; rsp_q = no_op;
      g_cnt[0] = 0; g_cnt[1] = 0; stall = 0;
    end else begin
      rsp_q   = cmd_q;
      rsp_q.v = rd_cmd;
      cmd_q   = no_op;
      if (g == 0 && p0_valid) accept(1'b0, p0_we, p0_addr, p0_wdata);
      if (g == 1 && p1_valid) accept(1'b1, p1_we, p1_addr, p1_wdata);
      if (p1_valid && g != 1) begin
        starve = (starve < SL) ? starve + 1 : SL;
        if (stall < 16'hFFFF) stall++;
      end else begin
        starve = 0;
      end
    end
    #1;
  endtask

  task automatic drive(input bit v0, input bit we0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input bit lk, input bit v1, input bit we1, input logic [AW-1:0] a1,
                       input logic [DW-1:0] d1);
    p0_valid = v0; p0_we = we0; p0_addr = a0; p0_wdata = d0; p0_lock = lk;
    p1_valid = v1; p1_we = we1; p1_addr = a1; p1_wdata = d1;
  endtask

  task automatic idle(input int n);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (n) cyc();
  endtask

  initial begin
    logic [DW-1:0] old5;
    logic [DW-1:0] w;
    bit            lk;
    no_op = '{v: 1'b0, we: 1'b0, port: 1'b0, addr: '0, data: '0};
    cmd_q = no_op; rsp_q = no_op; starve = 0; stall = 0; g_cnt[0] = 0; g_cnt[1] = 0;
    for (int i = 0; i < 256; i++) begin
      w = $urandom;
      env_mem[i] = w;
      ref_mem[i] = w;
    end
    env_mem[8'h12] = 32'hDEADBEEF;
    ref_mem[8'h12] = 32'hDEADBEEF;

    // Reset held with both ports requesting
    rst_in = 1'b1;
    drive(1, 0, 8'h10, 0, 0, 1, 0, 8'h20, 0);
    repeat (3) cyc();
    chk("rst_read_addr", ext_mem_read_addr, 0);
    chk("rst_write_addr", ext_mem_write_addr, 0);
    chk("rst_din", ext_mem_din, 0);
    chk("rst_p0_rsp_data", p0_rsp_data, 0);
    rst_in = 1'b0;
    cyc();
    idle(4);

    // Single read of a known word
    drive(1, 0, 8'h12, 0, 0, 0, 0, 0, 0);
    cyc();
    idle(3);

    // Starvation: both ports busy continuously
    for (int i = 0; i < 15; i++) begin
      drive(1, $urandom_range(0, 1), AW'($urandom), $urandom, 0, 1, 0, AW'($urandom), 0);
      cyc();
    end
    idle(3);

    // Locked read-modify-write with port 1 waiting on the same address
    old5 = ref_mem[8'h05];
    drive(1, 0, 8'h05, 0, 1, 1, 0, 8'h05, 0);
    cyc();
    drive(0, 0, 8'h05, 0, 1, 1, 0, 8'h05, 0);
    cyc();
    drive(1, 1, 8'h05, old5 + 32'd7, 1, 1, 0, 8'h05, 0);
    cyc();
    drive(0, 0, 0, 0, 0, 1, 0, 8'h05, 0);
    cyc();
    chk("lock_rmw_value", ref_mem[8'h05], old5 + 32'd7);
    idle(3);

    // Interleaved reads across ports
    drive(1, 0, 8'h01, 0, 0, 0, 0, 0, 0);
    cyc();
    drive(0, 0, 0, 0, 0, 1, 0, 8'h02, 0);
    cyc();
    drive(1, 0, 8'h03, 0, 0, 0, 0, 0, 0);
    cyc();
    idle(4);

    // Reset while a read command is on the memory pins
    drive(1, 0, 8'h40, 0, 0, 0, 0, 0, 0);
    cyc();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_in = 1'b1;
    cyc();
    rst_in = 1'b0;
    idle(3);

    // Random traffic over a small address window to provoke hazards
    lk = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) lk = ~lk;
      rst_in = ($urandom_range(0, 99) == 0);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1), AW'($urandom_range(0, 7)), $urandom, lk,
            $urandom_range(0, 2) != 0, $urandom_range(0, 1), AW'($urandom_range(0, 7)), $urandom);
      cyc();
    end
    rst_in = 1'b0;
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
